// File: rtl/pid_frame_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pid_frame_sequencer_pkg
//   Shared constants and types for the PID frame sequencer slice.
//   - N_WIND_TURBINE : default number of wind-turbine channels per frame
//   - SINGLE_W       : width of one IEEE-754 single-precision sample
//   - seq_state_t    : sequencer FSM encodings SEQ_IDLE..SEQ_CAPTURE
//   - max3()         : elaboration-time helper for sizing counters
// ----------------------------------------------------------------------------
package pid_frame_sequencer_pkg;

   localparam int N_WIND_TURBINE = 8;
   localparam int SINGLE_W       = 32;

   localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_LEAD    = 3'd1,
      SEQ_ISSUE   = 3'd2,
      SEQ_WAIT    = 3'd3,
      SEQ_CAPTURE = 3'd4
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pid_seq_bank.sv
// ----------------------------------------------------------------------------
// pid_seq_bank
//   N_CH x 32-bit register bank with an optional snapshot copy.
//   With HAS_SNAP=1 a shadow bank takes host writes at any time and 'snap'
//   copies it into an active bank; a write in the snapshot cycle is carried
//   straight into the active copy. Reads come from the active bank.
//   With HAS_SNAP=0 the bank is a plain register file read from the shadow.
//
//   Ports:
//     clk, rst_user : clock, asynchronous active-high reset
//     we/waddr/wdata: write port into the shadow registers
//     snap          : copy shadow -> active (HAS_SNAP=1 only)
//     raddr/rdata   : combinational indexed read
// ----------------------------------------------------------------------------
module pid_seq_bank
   import pid_frame_sequencer_pkg::*;
#(
   parameter int N_CH     = N_WIND_TURBINE,
   parameter bit HAS_SNAP = 1'b1
)(
   input  logic                     clk,
   input  logic                     rst_user,
   input  logic                     we,
   input  logic [$clog2(N_CH)-1:0]  waddr,
   input  logic [SINGLE_W-1:0]      wdata,
   input  logic                     snap,
   input  logic [$clog2(N_CH)-1:0]  raddr,
   output logic [SINGLE_W-1:0]      rdata
);

   localparam int AW = $clog2(N_CH);

   logic [SINGLE_W-1:0] shadow_q [N_CH];

   // NOTE: sequential state is always assigned with <= so every register
   // samples pre-edge values, regardless of block ordering.
   // NOTE: the banks are small register arrays, not RAM macros, so they are
   // cleared by reset along with the rest of the state.
   always_ff @(posedge clk or posedge rst_user) begin
      if (rst_user) begin
         for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
      end else if (we) begin
         shadow_q[waddr] <= wdata;
      end
   end

   generate
      if (HAS_SNAP) begin : g_snap
         logic [SINGLE_W-1:0] active_q [N_CH];

         always_ff @(posedge clk or posedge rst_user) begin
            if (rst_user) begin
               for (int i = 0; i < N_CH; i++) active_q[i] <= '0;
            end else if (snap) begin
               // Write-through: a host write landing in the snapshot cycle
               // is part of the frame.
               for (int i = 0; i < N_CH; i++) begin
                  active_q[i] <= (we && (waddr == AW'(i))) ? wdata : shadow_q[i];
               end
            end
         end

         assign rdata = active_q[raddr];
      end else begin : g_direct
         logic unused_snap;
         assign unused_snap = snap;
         assign rdata       = shadow_q[raddr];
      end
   endgenerate

endmodule

// File: rtl/pid_frame_sequencer.sv
// ----------------------------------------------------------------------------
// pid_frame_sequencer
//   Initiator side of the time-multiplexed PID pipelines. Per accepted step:
//   done_read pulse, LEAD cycles later a sta pulse with the first of N_CH
//   samples on x, then the returned y stream (marked by done_sig) is captured
//   into a result bank that the host reads with one cycle of latency.
//
//   Ports:
//     clk, rst_user         : clock, asynchronous active-high reset
//     step                  : frame request (dropped and counted when busy)
//     in_we/in_addr/in_data : host writes into the input shadow bank
//     done_read, sta, x     : frame start pulse, first-word pulse, sample bus
//     done_sig, y           : returned result stream from the PID block
//     res_addr, res_data    : registered result-bank read
//     busy, frame_done      : activity flag, end-of-frame pulse
//     timeout               : sticky "no done_sig in time" flag
//     overrun_cnt           : saturating count of dropped step requests
// ----------------------------------------------------------------------------
module pid_frame_sequencer
   import pid_frame_sequencer_pkg::*;
#(
   parameter int N_CH    = N_WIND_TURBINE,
   parameter int LEAD    = 15,
   parameter int RES_LAT = 20,
   parameter int TMO     = 16
)(
   input  logic                     clk,
   input  logic                     rst_user,
   input  logic                     step,
   input  logic                     in_we,
   input  logic [$clog2(N_CH)-1:0]  in_addr,
   input  logic [SINGLE_W-1:0]      in_data,
   output logic                     done_read,
   output logic                     sta,
   output logic [SINGLE_W-1:0]      x,
   input  logic                     done_sig,
   input  logic [SINGLE_W-1:0]      y,
   input  logic [$clog2(N_CH)-1:0]  res_addr,
   output logic [SINGLE_W-1:0]      res_data,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     timeout,
   output logic [15:0]              overrun_cnt
);

   localparam int AW = $clog2(N_CH);
   // One counter serves LEAD timing, the ISSUE index and the elapsed time
   // since sta while waiting, so it must hold the largest of the three.
   localparam int CW = $clog2(max3(LEAD, RES_LAT + TMO, N_CH) + 1);

   localparam logic [CW-1:0] LEAD_LAST  = CW'(LEAD - 1);
   localparam logic [CW-1:0] ISSUE_LAST = CW'(N_CH - 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(RES_LAT + TMO - 1);
   localparam logic [AW-1:0] CAP_LAST   = AW'(N_CH - 1);

   seq_state_t          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                cap_active_q, cap_active_d;
   logic [AW-1:0]       cap_idx_q, cap_idx_d;
   logic                frame_done_q, frame_done_d;
   logic                timeout_q, timeout_d;
   logic [15:0]         overrun_q;
   logic [SINGLE_W-1:0] res_data_q;

   logic                accept;
   logic                cap_last;
   logic                res_we;
   logic [AW-1:0]       res_waddr;
   logic [SINGLE_W-1:0] in_rdata;
   logic [SINGLE_W-1:0] res_rdata;

   // A step in the frame_done cycle is treated like a step while busy.
   assign accept   = (state_q == SEQ_IDLE) && step && !frame_done_q;
   assign cap_last = cap_active_q && (cap_idx_q == CAP_LAST);

   // ---------------------------------------------------------------------
   // Banks
   // ---------------------------------------------------------------------
   pid_seq_bank #(
      .N_CH     (N_CH),
      .HAS_SNAP (1'b1)
   ) u_in_bank (
      .clk      (clk),
      .rst_user (rst_user),
      .we       (in_we),
      .waddr    (in_addr),
      .wdata    (in_data),
      .snap     (accept),
      .raddr    (cnt_q[AW-1:0]),
      .rdata    (in_rdata)
   );

   pid_seq_bank #(
      .N_CH     (N_CH),
      .HAS_SNAP (1'b0)
   ) u_res_bank (
      .clk      (clk),
      .rst_user (rst_user),
      .we       (res_we),
      .waddr    (res_waddr),
      .wdata    (y),
      .snap     (1'b0),
      .raddr    (res_addr),
      .rdata    (res_rdata)
   );

   // ---------------------------------------------------------------------
   // Next-state / capture logic
   // ---------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_active_d = cap_active_q;
      cap_idx_d    = cap_idx_q;
      frame_done_d = 1'b0;
      timeout_d    = timeout_q;
      res_we       = 1'b0;
      res_waddr    = cap_idx_q;

      // The capture engine runs independently of the issue index so that a
      // done_sig arriving while samples are still going out is honoured.
      if (cap_active_q) begin
         res_we    = 1'b1;
         res_waddr = cap_idx_q;
         if (cap_last) begin
            cap_active_d = 1'b0;
            cap_idx_d    = '0;
         end else begin
            cap_idx_d = cap_idx_q + AW'(1);
         end
      end else if (done_sig && ((state_q == SEQ_ISSUE) || (state_q == SEQ_WAIT))) begin
         res_we       = 1'b1;
         res_waddr    = '0;
         cap_active_d = 1'b1;
         cap_idx_d    = AW'(1);
      end

      unique case (state_q)
         SEQ_IDLE: begin
            cnt_d = '0;
            if (accept) state_d = SEQ_LEAD;
         end
         SEQ_LEAD: begin
            if (cnt_q == LEAD_LAST) begin
               state_d = SEQ_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SEQ_ISSUE: begin
            // cnt keeps running past ISSUE: it is the time since sta.
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == ISSUE_LAST) begin
               if (cap_last) begin
                  state_d      = SEQ_IDLE;
                  frame_done_d = 1'b1;
               end else if (cap_active_d) begin
                  state_d = SEQ_CAPTURE;
               end else begin
                  state_d = SEQ_WAIT;
               end
            end
         end
         SEQ_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cap_active_d) begin
               state_d = SEQ_CAPTURE;
            end else if (cnt_q >= WAIT_LAST) begin
               state_d   = SEQ_IDLE;
               timeout_d = 1'b1;
            end
         end
         SEQ_CAPTURE: begin
            if (cap_last) begin
               state_d      = SEQ_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_user) begin
      if (rst_user) begin
         state_q      <= SEQ_IDLE;
         cnt_q        <= '0;
         cap_active_q <= 1'b0;
         cap_idx_q    <= '0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= '0;
         res_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cap_active_q <= cap_active_d;
         cap_idx_q    <= cap_idx_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
         // Registered from the pre-edge bank contents, so a same-cycle
         // write to the addressed entry returns the old value.
         res_data_q   <= res_rdata;
         if (step && ((state_q != SEQ_IDLE) || frame_done_q) && (overrun_q != OVERRUN_MAX)) begin
            overrun_q <= overrun_q + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded from registered state, so reset clears them at once.
   // ---------------------------------------------------------------------
   assign busy        = (state_q != SEQ_IDLE);
   assign done_read   = (state_q == SEQ_LEAD) && (cnt_q == '0);
   assign sta         = (state_q == SEQ_ISSUE) && (cnt_q == '0);
   assign x           = (state_q == SEQ_ISSUE) ? in_rdata : '0;
   assign frame_done  = frame_done_q;
   assign timeout     = timeout_q;
   assign overrun_cnt = overrun_q;
   assign res_data    = res_data_q;

endmodule

// File: tb/tb_pid_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pid_frame_sequencer
//   Directed bench for pid_frame_sequencer (N_CH=8, LEAD=15, RES_LAT=20,
//   TMO=16). Cycle 0 of each frame is the first cycle run_frame drives; the
//   step request is always raised in cycle 10. The PID block is modelled as
//   a 20-cycle delay of sta/x onto done_sig/y.
// ----------------------------------------------------------------------------
module tb_pid_frame_sequencer;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int HN = 80;

   logic          clk;
   logic          rst_user;
   logic          step;
   logic          in_we;
   logic [AW-1:0] in_addr;
   logic [31:0]   in_data;
   logic          done_read;
   logic          sta;
   logic [31:0]   x;
   logic          done_sig;
   logic [31:0]   y;
   logic [AW-1:0] res_addr;
   logic [31:0]   res_data;
   logic          busy;
   logic          frame_done;
   logic          timeout;
   logic [15:0]   overrun_cnt;

   int total = 0;
   int bad   = 0;
   bit pid_en;

   logic [HN-1:0] h_sta, h_dr, h_busy, h_fd, h_to;
   logic [31:0]   h_x   [HN];
   logic [31:0]   h_res [HN];

   pid_frame_sequencer #(
      .N_CH    (N),
      .LEAD    (15),
      .RES_LAT (20),
      .TMO     (16)
   ) dut (
      .clk         (clk),
      .rst_user    (rst_user),
      .step        (step),
      .in_we       (in_we),
      .in_addr     (in_addr),
      .in_data     (in_data),
      .done_read   (done_read),
      .sta         (sta),
      .x           (x),
      .done_sig    (done_sig),
      .y           (y),
      .res_addr    (res_addr),
      .res_data    (res_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout     (timeout),
      .overrun_cnt (overrun_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Callers are always positioned 1 time unit after a rising edge.
   task automatic write_shadow(input int k, input logic [31:0] d);
      in_we   = 1'b1;
      in_addr = AW'(k);
      in_data = d;
      @(posedge clk); #1;
      in_we   = 1'b0;
   endtask

   task automatic read_res(input int k, input logic [31:0] exp, input string tag);
      res_addr = AW'(k);
      @(posedge clk); #1;
      check(tag, res_data, exp);
   endtask

   // Runs n_cyc cycles with step in cycle 10, recording outputs per cycle.
   // extra_steps adds requests at 20 and 54; snap_writes adds host writes to
   // channel 3 in cycles 10 and 15.
   task automatic run_frame(input int n_cyc, input bit extra_steps, input bit snap_writes);
      h_sta = '0; h_dr = '0; h_busy = '0; h_fd = '0; h_to = '0;
      for (int c = 0; c < n_cyc; c++) begin
         step    = (c == 10) || (extra_steps && ((c == 20) || (c == 54)));
         in_we   = 1'b0;
         in_addr = '0;
         in_data = '0;
         if (snap_writes && (c == 10)) begin
            in_we = 1'b1; in_addr = 3'd3; in_data = 32'h40400000;
         end
         if (snap_writes && (c == 15)) begin
            in_we = 1'b1; in_addr = 3'd3; in_data = 32'h40800000;
         end
         done_sig = pid_en && (c >= 20) && h_sta[c-20];
         y        = (c >= 20) ? h_x[c-20] : 32'h0;
         #1;
         h_sta[c]  = sta;
         h_dr[c]   = done_read;
         h_busy[c] = busy;
         h_fd[c]   = frame_done;
         h_to[c]   = timeout;
         h_x[c]    = x;
         h_res[c]  = res_data;
         @(posedge clk); #1;
      end
      step = 1'b0; in_we = 1'b0; done_sig = 1'b0; y = '0;
   endtask

   initial begin
      rst_user = 1'b1; step = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0;
      done_sig = 1'b0; y = '0; res_addr = '0; pid_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_user = 1'b0;
      @(posedge clk); #1;

      // ---- reset state ----
      check("rst_done_read",  32'(done_read),   32'd0);
      check("rst_sta",        32'(sta),         32'd0);
      check("rst_x",          x,                32'd0);
      check("rst_busy",       32'(busy),        32'd0);
      check("rst_frame_done", 32'(frame_done),  32'd0);
      check("rst_timeout",    32'(timeout),     32'd0);
      check("rst_overrun",    32'(overrun_cnt), 32'd0);
      check("rst_res_data",   res_data,         32'd0);

      // ---- frame 1: directed loopback with overrun requests ----
      for (int k = 0; k < N; k++) write_shadow(k, 32'h3F800000 + 32'(k));
      run_frame(70, 1'b1, 1'b0);
      check("f1_done_read_at_11", 32'(h_dr[11]),          32'd1);
      check("f1_done_read_count", 32'($countones(h_dr)),  32'd1);
      check("f1_sta_at_26",       32'(h_sta[26]),         32'd1);
      check("f1_sta_count",       32'($countones(h_sta)), 32'd1);
      check("f1_x_before",        h_x[25],                32'd0);
      for (int k = 0; k < N; k++)
         check($sformatf("f1_x%0d", k), h_x[26+k], 32'h3F800000 + 32'(k));
      check("f1_x_after",         h_x[34],                32'd0);
      check("f1_busy_10",         32'(h_busy[10]),        32'd0);
      check("f1_busy_11",         32'(h_busy[11]),        32'd1);
      check("f1_busy_53",         32'(h_busy[53]),        32'd1);
      check("f1_busy_54",         32'(h_busy[54]),        32'd0);
      check("f1_busy_count",      32'($countones(h_busy)), 32'd43);
      check("f1_frame_done_54",   32'(h_fd[54]),          32'd1);
      check("f1_frame_done_cnt",  32'($countones(h_fd)),  32'd1);
      check("f1_no_timeout",      32'($countones(h_to)),  32'd0);
      check("f1_overrun",         32'(overrun_cnt),       32'd2);
      for (int k = 0; k < N; k++)
         read_res(k, 32'h3F800000 + 32'(k), $sformatf("f1_res%0d", k));

      // ---- frame 2: snapshot write-through, read-during-write ----
      write_shadow(0, 32'h11111111);
      res_addr = '0;
      run_frame(60, 1'b0, 1'b1);
      check("f2_x0",              h_x[26],               32'h11111111);
      check("f2_x3_snapshot",     h_x[29],               32'h40400000);
      check("f2_res0_old",        h_res[47],             32'h3F800000);
      check("f2_res0_new",        h_res[48],             32'h11111111);
      check("f2_frame_done_54",   32'(h_fd[54]),         32'd1);
      check("f2_overrun",         32'(overrun_cnt),      32'd2);
      read_res(3, 32'h40400000, "f2_res3");
      read_res(5, 32'h3F800005, "f2_res5");

      // ---- frame 3: timeout, PID block silent ----
      pid_en = 1'b0;
      run_frame(66, 1'b0, 1'b0);
      pid_en = 1'b1;
      check("f3_x3_shadow_kept",  h_x[29],               32'h40800000);
      check("f3_timeout_61",      32'(h_to[61]),         32'd0);
      check("f3_timeout_62",      32'(h_to[62]),         32'd1);
      check("f3_busy_61",         32'(h_busy[61]),       32'd1);
      check("f3_busy_62",         32'(h_busy[62]),       32'd0);
      check("f3_no_frame_done",   32'($countones(h_fd)), 32'd0);
      check("f3_timeout_sticky",  32'(timeout),          32'd1);
      read_res(3, 32'h40400000, "f3_res3_unchanged");
      read_res(0, 32'h11111111, "f3_res0_unchanged");

      // ---- frame 4: reset during ISSUE, then a clean frame ----
      run_frame(29, 1'b0, 1'b0);
      check("f4_sta_26",          32'(h_sta[26]),        32'd1);
      check("f4_issuing",         x,                     32'h40800000);
      rst_user = 1'b1;
      #1;
      check("f4_rst_busy",        32'(busy),             32'd0);
      check("f4_rst_sta",         32'(sta),              32'd0);
      check("f4_rst_x",           x,                     32'd0);
      check("f4_rst_done_read",   32'(done_read),        32'd0);
      check("f4_rst_frame_done",  32'(frame_done),       32'd0);
      check("f4_rst_timeout",     32'(timeout),          32'd0);
      check("f4_rst_overrun",     32'(overrun_cnt),      32'd0);
      check("f4_rst_res_data",    res_data,              32'd0);
      @(posedge clk); #1;
      rst_user = 1'b0;
      @(posedge clk); #1;
      read_res(3, 32'd0, "f4_res3_cleared");
      for (int k = 0; k < N; k++) write_shadow(k, 32'hC0A00000 + 32'(k));
      run_frame(60, 1'b0, 1'b0);
      check("f5_done_read_at_11", 32'(h_dr[11]),         32'd1);
      check("f5_sta_at_26",       32'(h_sta[26]),        32'd1);
      for (int k = 0; k < N; k++)
         check($sformatf("f5_x%0d", k), h_x[26+k], 32'hC0A00000 + 32'(k));
      check("f5_frame_done_54",   32'(h_fd[54]),         32'd1);
      check("f5_frame_done_cnt",  32'($countones(h_fd)), 32'd1);
      check("f5_no_timeout",      32'(timeout),          32'd0);
      for (int k = 0; k < N; k++)
         read_res(k, 32'hC0A00000 + 32'(k), $sformatf("f5_res%0d", k));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
